// File: rtl/serv_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// serv_mem_arbiter_pkg
//   Shared types and helpers for the three-way Wishbone memory arbiter.
//   - owner_e  : registered owner of the memory port (NONE/IBUS/DBUS/EXT)
//   - state_e  : grant FSM states (IDLE/BUSY)
//   - wb_req_t : one requester's Wishbone-classic request bundle
//   - pick_owner() : arbitration decision taken in IDLE
// -----------------------------------------------------------------------------
package serv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IBUS = 2'd1,
    OWN_DBUS = 2'd2,
    OWN_EXT  = 2'd3
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '0;

  // Data bus beats instruction bus inside the core; core vs host is
  // round-robin: last_core=1 means the core won last time, so the host wins.
  function automatic owner_e pick_owner(input logic ibus_cyc,
                                        input logic dbus_cyc,
                                        input logic ext_cyc,
                                        input logic last_core);
    owner_e core_own;
    logic   core_cyc;
    core_cyc = ibus_cyc | dbus_cyc;
    core_own = dbus_cyc ? OWN_DBUS : OWN_IBUS;
    if (core_cyc && ext_cyc) pick_owner = last_core ? OWN_EXT : core_own;
    else if (core_cyc)       pick_owner = core_own;
    else if (ext_cyc)        pick_owner = OWN_EXT;
    else                     pick_owner = OWN_NONE;
  endfunction

endpackage

// File: rtl/serv_arb_timer.sv
// -----------------------------------------------------------------------------
// serv_arb_timer
//   Access watchdog for serv_mem_arbiter (only instantiated when
//   SERV_ARB_TIMEOUT_EN is defined).
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     i_clear      : grant strobe, restarts the count
//     i_busy       : arbiter is in BUSY
//     i_ack        : memory ack this cycle (no increment)
//     o_expire     : counter has reached TIMEOUT while BUSY
// -----------------------------------------------------------------------------
module serv_arb_timer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign o_expire = i_busy && (cnt_q == TO_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)                           cnt_d = '0;
    else if (i_busy && !i_ack && !o_expire) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// serv_mem_arbiter
//   Shares one Wishbone-classic memory port between the SERV instruction bus
//   (read-only), the SERV data bus and an external host/DMA port. A registered
//   grant FSM holds the owner until its ack (or abort); core vs host is
//   round-robin. Optional watchdog enabled by the macro SERV_ARB_TIMEOUT_EN.
//   Ports:
//     i_clk, i_rst                        clock, synchronous active-high reset
//     i_ibus_*, o_ibus_rdt/ack            instruction fetch port
//     i_dbus_*, o_dbus_rdt/ack            core data port
//     i_ext_*,  o_ext_rdt/ack             host/DMA port
//     o_wb_mem_*, i_wb_mem_rdt/ack        shared memory port
//     o_timeout                           pulse on forced termination
//   Parameters: TIMEOUT (1..2^TO_W-1), TO_W.
// -----------------------------------------------------------------------------
module serv_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic [31:0] i_ext_adr,
  input  logic [31:0] i_ext_dat,
  input  logic [3:0]  i_ext_sel,
  input  logic        i_ext_we,
  input  logic        i_ext_cyc,
  output logic [31:0] o_ext_rdt,
  output logic        o_ext_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_cyc,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_timeout
);

  import serv_mem_arbiter_pkg::*;

  if (TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_timeout
    $error("serv_mem_arbiter: TIMEOUT must be in 1..2^TO_W-1");
  end

  state_e  state_q, state_d;
  owner_e  owner_q, owner_d;
  logic    last_core_q, last_core_d;
  owner_e  winner;
  wb_req_t ibus_req, dbus_req, ext_req, own_req;
  logic    busy, own_cyc, done_ack, expire, timeout_hit, ack_pulse;
  logic [31:0] rdt;

  // The instruction bus is a read-only full-word fetch.
  assign ibus_req = '{adr: i_ibus_adr, dat: 32'h0, sel: 4'hF, we: 1'b0, cyc: i_ibus_cyc};
  assign dbus_req = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we, cyc: i_dbus_cyc};
  assign ext_req  = '{adr: i_ext_adr, dat: i_ext_dat, sel: i_ext_sel, we: i_ext_we, cyc: i_ext_cyc};

  assign winner = pick_owner(i_ibus_cyc, i_dbus_cyc, i_ext_cyc, last_core_q);
  assign busy   = (state_q == ST_BUSY);

  always_comb begin : own_mux
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    own_req = WB_REQ_IDLE;
    case (owner_q)
      OWN_IBUS: own_req = ibus_req;
      OWN_DBUS: own_req = dbus_req;
      OWN_EXT:  own_req = ext_req;
      default:  own_req = WB_REQ_IDLE;
    endcase
  end

  // An owner that has dropped cyc has aborted: its late ack is swallowed.
  assign own_cyc     = busy && own_req.cyc;
  assign done_ack    = own_cyc && i_wb_mem_ack;
  // A real ack in the expiry cycle wins over the timeout.
  assign timeout_hit = own_cyc && expire && !i_wb_mem_ack;
  assign ack_pulse   = done_ack || timeout_hit;

`ifdef SERV_ARB_TIMEOUT_EN
  logic grant;
  assign grant = (state_q == ST_IDLE) && (winner != OWN_NONE);

  serv_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (grant),
    .i_busy   (busy),
    .i_ack    (i_wb_mem_ack),
    .o_expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      last_core_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_core_q <= last_core_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_core_d = last_core_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          state_d     = ST_BUSY;
          owner_d     = winner;
          last_core_d = (winner != OWN_EXT);
        end
      end
      ST_BUSY: begin
        // Leave on ack, timeout or abort; IDLE then gives one dead cycle.
        if (!own_cyc || ack_pulse) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_wb_mem_adr = 32'h0;
    o_wb_mem_dat = 32'h0;
    o_wb_mem_sel = 4'h0;
    o_wb_mem_we  = 1'b0;
    o_wb_mem_cyc = 1'b0;
    if (busy) begin
      o_wb_mem_adr = own_req.adr;
      o_wb_mem_dat = own_req.dat;
      o_wb_mem_sel = own_req.sel;
      o_wb_mem_we  = own_req.we;
      o_wb_mem_cyc = own_req.cyc;
    end
    rdt        = timeout_hit ? 32'h0 : i_wb_mem_rdt;
    o_ibus_rdt = rdt;
    o_dbus_rdt = rdt;
    o_ext_rdt  = rdt;
    o_ibus_ack = ack_pulse && (owner_q == OWN_IBUS);
    o_dbus_ack = ack_pulse && (owner_q == OWN_DBUS);
    o_ext_ack  = ack_pulse && (owner_q == OWN_EXT);
    o_timeout  = timeout_hit;
  end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serv_mem_arbiter
//   Directed bench for serv_mem_arbiter: reset state, ibus fetch, dbus write,
//   reset mid-access, host abort, core/host round-robin, ibus/dbus contest,
//   and the watchdog (SERV_ARB_TIMEOUT_EN) or its absence.
// -----------------------------------------------------------------------------
module tb_serv_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr, i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we, i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] i_ext_adr, i_ext_dat;
  logic [3:0]  i_ext_sel;
  logic        i_ext_we, i_ext_cyc;
  logic [31:0] o_ext_rdt;
  logic        o_ext_ack;
  logic [31:0] o_wb_mem_adr, o_wb_mem_dat;
  logic [3:0]  o_wb_mem_sel;
  logic        o_wb_mem_we, o_wb_mem_cyc;
  logic [31:0] i_wb_mem_rdt;
  logic        i_wb_mem_ack;
  logic        o_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serv_mem_arbiter #(
    .TIMEOUT (4),
    .TO_W    (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_ibus_adr   (i_ibus_adr),
    .i_ibus_cyc   (i_ibus_cyc),
    .o_ibus_rdt   (o_ibus_rdt),
    .o_ibus_ack   (o_ibus_ack),
    .i_dbus_adr   (i_dbus_adr),
    .i_dbus_dat   (i_dbus_dat),
    .i_dbus_sel   (i_dbus_sel),
    .i_dbus_we    (i_dbus_we),
    .i_dbus_cyc   (i_dbus_cyc),
    .o_dbus_rdt   (o_dbus_rdt),
    .o_dbus_ack   (o_dbus_ack),
    .i_ext_adr    (i_ext_adr),
    .i_ext_dat    (i_ext_dat),
    .i_ext_sel    (i_ext_sel),
    .i_ext_we     (i_ext_we),
    .i_ext_cyc    (i_ext_cyc),
    .o_ext_rdt    (o_ext_rdt),
    .o_ext_ack    (o_ext_ack),
    .o_wb_mem_adr (o_wb_mem_adr),
    .o_wb_mem_dat (o_wb_mem_dat),
    .o_wb_mem_sel (o_wb_mem_sel),
    .o_wb_mem_we  (o_wb_mem_we),
    .o_wb_mem_cyc (o_wb_mem_cyc),
    .i_wb_mem_rdt (i_wb_mem_rdt),
    .i_wb_mem_ack (i_wb_mem_ack),
    .o_timeout    (o_timeout)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // a further unit later, well clear of the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic seen_ack;
    int   wait_cyc;
    int   dbus_grants;
    int   ext_grants;

    i_rst = 1'b1;
    i_ibus_adr = '0; i_ibus_cyc = 1'b0;
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    i_ext_adr  = '0; i_ext_dat  = '0; i_ext_sel  = '0; i_ext_we  = 1'b0; i_ext_cyc  = 1'b0;
    i_wb_mem_rdt = 32'h0; i_wb_mem_ack = 1'b0;

    // Reset state
    step(); step();
    #1;
    check("reset_outputs", {o_wb_mem_cyc, o_ibus_ack, o_dbus_ack, o_ext_ack, o_timeout}, 5'b0);
    i_rst = 1'b0;
    step();

    // Instruction fetch at 0x100, memory acks two cycles after cyc rises
    i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1;
    #1;
    check("ibus_arb_latency", o_wb_mem_cyc, 1'b0);
    step();
    check("ibus_granted", {o_wb_mem_cyc, o_wb_mem_we, o_wb_mem_adr}, {2'b10, 32'h100});
    step();
    check("ibus_wait_no_ack", o_ibus_ack, 1'b0);
    i_wb_mem_ack = 1'b1; i_wb_mem_rdt = 32'hDEADBEEF;
    #1;
    check("ibus_ack", {o_ibus_ack, o_dbus_ack, o_ext_ack, o_ibus_rdt}, {3'b100, 32'hDEADBEEF});
    step();
    i_wb_mem_ack = 1'b0; i_ibus_cyc = 1'b0;
    #1;
    check("ibus_idle_after", {o_wb_mem_cyc, o_ibus_ack}, 2'b00);

    // Data bus write
    step();
    i_dbus_adr = 32'h2000; i_dbus_dat = 32'hA5A5A5A5; i_dbus_sel = 4'b0011;
    i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    step();
    check("dbus_wr_port", {o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc},
          {32'h2000, 32'hA5A5A5A5, 4'b0011, 2'b11});
    i_wb_mem_ack = 1'b1;
    #1;
    check("dbus_wr_ack", {o_ibus_ack, o_dbus_ack, o_ext_ack}, 3'b010);
    step();
    i_wb_mem_ack = 1'b0; i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
    #1;
    check("dbus_wr_idle", {o_wb_mem_cyc, o_dbus_ack}, 2'b00);

    // Reset while BUSY, then a normal grant
    step();
    i_ext_adr = 32'h3000; i_ext_we = 1'b0; i_ext_sel = 4'hF; i_ext_cyc = 1'b1;
    step();
    check("rst_pre_busy", {o_wb_mem_cyc, o_wb_mem_adr}, {1'b1, 32'h3000});
    i_rst = 1'b1;
    step();
    check("rst_mid_access", {o_wb_mem_cyc, o_ibus_ack, o_dbus_ack, o_ext_ack}, 4'b0);
    i_rst = 1'b0;
    step();
    check("rst_regrant", {o_wb_mem_cyc, o_wb_mem_adr}, {1'b1, 32'h3000});
    i_wb_mem_ack = 1'b1;
    #1;
    check("rst_regrant_ack", {o_ibus_ack, o_dbus_ack, o_ext_ack}, 3'b001);
    step();
    i_wb_mem_ack = 1'b0; i_ext_cyc = 1'b0;

    // Host aborts, then a late memory ack arrives
    step();
    i_ext_adr = 32'h3100; i_ext_cyc = 1'b1;
    step();
    check("abort_busy", o_wb_mem_cyc, 1'b1);
    i_ext_cyc = 1'b0;
    step();
    i_wb_mem_ack = 1'b1;
    #1;
    check("abort_late_ack", {o_wb_mem_cyc, o_ibus_ack, o_dbus_ack, o_ext_ack}, 4'b0);
    step();
    i_wb_mem_ack = 1'b0;

    // Core vs host round-robin: last grant was host, so dbus goes first
    step();
    i_dbus_adr = 32'h4000; i_dbus_we = 1'b0; i_dbus_cyc = 1'b1;
    i_ext_adr  = 32'h5000; i_ext_we  = 1'b0; i_ext_cyc  = 1'b1;
    dbus_grants = 0; ext_grants = 0;
    for (int n = 0; n < 20; n++) begin
      wait_cyc = 0;
      #1;
      while (!o_wb_mem_cyc && wait_cyc < 10) begin
        step();
        #1;
        wait_cyc++;
      end
      check("fair_grant", o_wb_mem_cyc, 1'b1);
      i_wb_mem_ack = 1'b1;
      #1;
      if (o_dbus_ack) dbus_grants++;
      if (o_ext_ack)  ext_grants++;
      check("fair_owner", {o_ibus_ack, o_dbus_ack, o_ext_ack, o_wb_mem_adr},
            (n % 2 == 0) ? {3'b010, 32'h4000} : {3'b001, 32'h5000});
      step();
      i_wb_mem_ack = 1'b0;
      if (n == 19) begin
        i_dbus_cyc = 1'b0;
        i_ext_cyc  = 1'b0;
      end
    end
    check("fair_counts", {dbus_grants[15:0], ext_grants[15:0]}, {16'd10, 16'd10});

    // ibus and dbus raised together: dbus wins, then ibus
    step();
    i_ibus_adr = 32'h6000; i_ibus_cyc = 1'b1;
    i_dbus_adr = 32'h7000; i_dbus_cyc = 1'b1;
    step();
    check("core_contest_dbus", {o_wb_mem_cyc, o_wb_mem_adr}, {1'b1, 32'h7000});
    i_wb_mem_ack = 1'b1;
    #1;
    check("core_contest_dbus_ack", {o_ibus_ack, o_dbus_ack, o_ext_ack}, 3'b010);
    step();
    i_wb_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
    step();
    check("core_contest_ibus", {o_wb_mem_cyc, o_wb_mem_adr}, {1'b1, 32'h6000});
    i_wb_mem_ack = 1'b1;
    #1;
    check("core_contest_ibus_ack", {o_ibus_ack, o_dbus_ack, o_ext_ack}, 3'b100);
    step();
    i_wb_mem_ack = 1'b0; i_ibus_cyc = 1'b0;

    // Memory that never acks
    step();
    i_wb_mem_rdt = 32'h12345678;
    i_dbus_adr = 32'h8000; i_dbus_cyc = 1'b1;
    step();
`ifdef SERV_ARB_TIMEOUT_EN
    step(); step(); step();
    check("to_before_expiry", {o_dbus_ack, o_timeout}, 2'b00);
    step();
    check("to_expiry", {o_dbus_ack, o_timeout, o_dbus_rdt}, {2'b11, 32'h0});
    step();
    i_dbus_cyc = 1'b0;
    #1;
    check("to_idle", {o_wb_mem_cyc, o_timeout}, 2'b00);
    // Real ack in the expiry cycle beats the timeout
    step();
    i_dbus_cyc = 1'b1;
    step();
    step(); step(); step(); step();
    i_wb_mem_ack = 1'b1;
    #1;
    check("to_ack_wins", {o_dbus_ack, o_timeout, o_dbus_rdt}, {2'b10, 32'h12345678});
    step();
    i_wb_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
`else
    seen_ack = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (o_dbus_ack || o_timeout) seen_ack = 1'b1;
    end
    check("no_timeout_1000", {seen_ack, o_wb_mem_cyc}, 2'b01);
    i_wb_mem_ack = 1'b1;
    #1;
    check("no_timeout_late_ack", {o_dbus_ack, o_timeout, o_dbus_rdt}, {2'b10, 32'h12345678});
    step();
    i_wb_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
`endif
    step();
    check("final_idle", o_wb_mem_cyc, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
